ballot_session_ctrl: RTL and testbench
======================================

// Module: ballot_session_ctrl
// PURPOSE
//  Front-end sequencer for the vote counter. Issues one ballot per officer
//  request, debounces the four candidate buttons and rejects multi-press.
//  Emits exactly one vote_valid pulse per ballot, or a timeout pulse.
//  Grants count readout (mode) only while no ballot is open.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive cycles a single button must stay held (>=1)
//  BALLOT_TIMEOUT   1000  cycles from ballot issue until an unused ballot expires (>=2)
// PORTS
//  clock         in   1  sole clock, rising edge
//  reset         in   1  synchronous, active-high
//  ballot_issue  in   1  officer request to open one ballot (level; edge not required)
//  mode          in   1  1 = readout request, 0 = voting
//  button1..4    in   1  raw candidate buttons, active-high
//  ballot_open   out  1  ballot currently open (ARMED/DEBOUNCE/REJECT)
//  vote_valid    out  1  one-cycle pulse: commit one vote
//  vote_cand     out  2  candidate index 0..3 (button1..4); valid with vote_valid
//  reject        out  1  one-cycle pulse: multi-press detected
//  timeout       out  1  one-cycle pulse: ballot expired unused
//  mode_grant    out  1  readout granted to the counter
//  ballots_cast  out  16 audit count of committed votes (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters cleared. A mid-ballot reset discards the ballot with no pulse.
//  Input sync: button1..4 registered into btn_q[3:0] every cycle; the FSM uses btn_q only.
//  States: IDLE, ARMED, DEBOUNCE, COMMIT, REJECT, RELEASE.
//  IDLE: mode=1 -> mode_grant=1 (registered, 1-cycle lag), stay IDLE.
//    mode=0 and ballot_issue=1 -> ARMED; tmo_cnt=0; mode_grant=0.
//    ballot_issue and mode both 1 -> readout wins, no ballot opened.
//  ARMED: btn_q one-hot -> DEBOUNCE, cand latched, deb_cnt=1.
//    btn_q has >=2 bits set -> REJECT. btn_q=0 -> stay.
//  DEBOUNCE: btn_q equals latched one-hot -> deb_cnt+1.
//    deb_cnt==DEBOUNCE_CYCLES -> COMMIT. btn_q==0 -> ARMED.
//    Other one-hot -> DEBOUNCE, relatch cand, deb_cnt=1. Multi-bit -> REJECT.
//  Latency: held press first captured at edge E0 -> vote_valid high after edge E0+DEBOUNCE_CYCLES+1.
//  COMMIT: vote_valid=1 and vote_cand=cand for exactly one cycle -> RELEASE.
//  REJECT: reject=1 for one cycle; ballot stays open. Waits for btn_q==0, then -> ARMED.
//  RELEASE: ballot_open=0; waits btn_q==0 -> IDLE. No new ballot until all buttons are released.
//  Timeout: tmo_cnt increments every cycle in ARMED/DEBOUNCE/REJECT.
//    At tmo_cnt==BALLOT_TIMEOUT-1: timeout=1 for one cycle -> RELEASE.
//    Debounce completion in the same cycle wins: COMMIT, no timeout.
//  ballot_issue outside IDLE is ignored. mode outside IDLE is ignored (mode_grant=0).
//  vote_cand holds its last value between pulses. vote_valid, reject and timeout are mutually exclusive.
//  Counters are sized $clog2(param+1); no wrap, they never exceed their terminal value.
// CONFIGURATION
//  BALLOT_AUDIT_EN defined: ballots_cast increments on each vote_valid.
//    Saturates at 16'hFFFF; cleared only by reset.
//  BALLOT_AUDIT_EN undefined: ballots_cast tied to 16'h0000; no counter logic is built.
// TESTING (bench: DEBOUNCE_CYCLES=4, BALLOT_TIMEOUT=50)
//  1. Issue, hold button2 8 cycles, release -> one vote_valid, vote_cand=1, at E0+5.
//     Then IDLE, ballot_open=0.
//  2. Issue, button2+button3 together -> reject=1 once, ballot_open stays 1.
//     Release, press button4 -> vote_cand=3.
//  3. Issue, button1 held 2 cycles, released, then held 6 -> deb restarts; exactly one vote, cand=0.
//  4. Issue, no press -> timeout pulse 50 cycles after issue, no vote_valid, IDLE.
//  5. mode=1 in IDLE -> mode_grant=1. During an open ballot, mode=1 -> mode_grant=0 and the ballot is unaffected.
//  6. Reset asserted mid-DEBOUNCE -> all outputs 0 next cycle, no vote.
//     With BALLOT_AUDIT_EN, 3 votes -> ballots_cast=3.

Source files
------------

// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl
//   Front-end sequencer for the vote counter. Opens one ballot per officer
//   request, debounces the four candidate buttons, rejects multi-press and
//   emits exactly one vote_valid pulse (or one timeout pulse) per ballot.
//   Count readout (mode_grant) is granted only while no ballot is open.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles a single button must stay held (>=1)
//   BALLOT_TIMEOUT   cycles from ballot issue until an unused ballot expires (>=2)
//
// Ports
//   clock         in   1   sole clock, rising edge
//   reset         in   1   synchronous, active-high
//   ballot_issue  in   1   officer request to open one ballot (level)
//   mode          in   1   1 = readout request, 0 = voting
//   button1..4    in   1   raw candidate buttons, active-high
//   ballot_open   out  1   ballot currently open
//   vote_valid    out  1   one-cycle pulse: commit one vote
//   vote_cand     out  2   candidate index 0..3, holds between pulses
//   reject        out  1   one-cycle pulse: multi-press detected
//   timeout       out  1   one-cycle pulse: ballot expired unused
//   mode_grant    out  1   readout granted to the counter
//   ballots_cast  out  16  audit count of committed votes
//
// Build option
//   BALLOT_AUDIT_EN  when defined, ballots_cast counts votes (saturating);
//                    otherwise it is tied to zero and no counter is built.

module ballot_session_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BALLOT_TIMEOUT  = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ballot_issue,
   input  logic        mode,
   input  logic        button1,
   input  logic        button2,
   input  logic        button3,
   input  logic        button4,
   output logic        ballot_open,
   output logic        vote_valid,
   output logic [1:0]  vote_cand,
   output logic        reject,
   output logic        timeout,
   output logic        mode_grant,
   output logic [15:0] ballots_cast
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(BALLOT_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DEBOUNCE,
      COMMIT,
      REJECT,
      RELEASE
   } state_t;

   state_t         state, state_next;
   logic [3:0]     btn_q;
   logic [3:0]     cand, cand_next;
   logic [DW-1:0]  deb_cnt, deb_next;
   logic [TW-1:0]  tmo_cnt, tmo_next;
   logic           reject_next, timeout_next;
   logic           btn_none, btn_multi, btn_one, tmo_last, deb_done;

   function automatic logic [1:0] cand_index(input logic [3:0] oh);
      logic [1:0] idx;
      idx = '0;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Clearing the lowest set bit leaves a nonzero value only when two or
   // more buttons are held together.
   always_comb begin
      btn_none  = (btn_q == '0);
      btn_multi = ((btn_q & (btn_q - 4'd1)) != '0);
      btn_one   = !btn_none && !btn_multi;
      tmo_last  = (tmo_cnt == TW'(BALLOT_TIMEOUT - 1));
      deb_done  = (btn_q == cand) && (deb_cnt == DW'(DEBOUNCE_CYCLES));
   end

   always_comb begin
      state_next   = state;
      cand_next    = cand;
      deb_next     = deb_cnt;
      tmo_next     = tmo_cnt;
      reject_next  = 1'b0;
      timeout_next = 1'b0;
      case (state)
         IDLE: begin
            // Readout request has priority over opening a ballot.
            if (!mode && ballot_issue) begin
               state_next = ARMED;
               tmo_next   = '0;
               deb_next   = '0;
            end
         end
         ARMED: begin
            if (tmo_last) begin
               timeout_next = 1'b1;
               state_next   = RELEASE;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
               if (btn_multi) begin
                  reject_next = 1'b1;
                  state_next  = REJECT;
               end else if (btn_one) begin
                  cand_next  = btn_q;
                  deb_next   = DW'(1);
                  state_next = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            // A debounce completing on the expiry cycle still commits.
            if (deb_done) begin
               state_next = COMMIT;
            end else if (tmo_last) begin
               timeout_next = 1'b1;
               state_next   = RELEASE;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
               if (btn_none) begin
                  state_next = ARMED;
               end else if (btn_multi) begin
                  reject_next = 1'b1;
                  state_next  = REJECT;
               end else if (btn_q == cand) begin
                  deb_next = deb_cnt + DW'(1);
               end else begin
                  cand_next = btn_q;
                  deb_next  = DW'(1);
               end
            end
         end
         COMMIT: begin
            state_next = RELEASE;
         end
         REJECT: begin
            if (tmo_last) begin
               timeout_next = 1'b1;
               state_next   = RELEASE;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
               if (btn_none) state_next = ARMED;
            end
         end
         RELEASE: begin
            if (btn_none) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         btn_q      <= '0;
         cand       <= '0;
         deb_cnt    <= '0;
         tmo_cnt    <= '0;
         vote_cand  <= '0;
         reject     <= 1'b0;
         timeout    <= 1'b0;
         mode_grant <= 1'b0;
      end else begin
         state      <= state_next;
         btn_q      <= {button4, button3, button2, button1};
         cand       <= cand_next;
         deb_cnt    <= deb_next;
         tmo_cnt    <= tmo_next;
         reject     <= reject_next;
         timeout    <= timeout_next;
         mode_grant <= (state == IDLE) && mode;
         if (state_next == COMMIT) vote_cand <= cand_index(cand);
      end
   end

   assign ballot_open = (state == ARMED) || (state == DEBOUNCE) || (state == REJECT);
   assign vote_valid  = (state == COMMIT);

`ifdef BALLOT_AUDIT_EN
   logic [15:0] cast_cnt;

   // Counts on the edge that raises vote_valid, so the two move together.
   always_ff @(posedge clock) begin
      if (reset) begin
         cast_cnt <= '0;
      end else if (state_next == COMMIT && cast_cnt != '1) begin
         cast_cnt <= cast_cnt + 16'd1;
      end
   end

   assign ballots_cast = cast_cnt;
`else
   assign ballots_cast = '0;
`endif

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// tb_ballot_session_ctrl
//   Self-checking bench for ballot_session_ctrl (DEBOUNCE_CYCLES=4,
//   BALLOT_TIMEOUT=50). A vector table, directed multi-cycle sequences and
//   randomized traffic, all compared each cycle against a ballot-level
//   reference model.

module tb_ballot_session_ctrl;

   localparam int DEB = 4;
   localparam int TMO = 50;

   logic        clock = 1'b0;
   logic        reset;
   logic        ballot_issue;
   logic        mode;
   logic [3:0]  btn;
   logic        ballot_open;
   logic        vote_valid;
   logic [1:0]  vote_cand;
   logic        reject;
   logic        timeout;
   logic        mode_grant;
   logic [15:0] ballots_cast;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clock = ~clock;

   ballot_session_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .BALLOT_TIMEOUT (TMO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ballot_issue(ballot_issue),
      .mode        (mode),
      .button1     (btn[0]),
      .button2     (btn[1]),
      .button3     (btn[2]),
      .button4     (btn[3]),
      .ballot_open (ballot_open),
      .vote_valid  (vote_valid),
      .vote_cand   (vote_cand),
      .reject      (reject),
      .timeout     (timeout),
      .mode_grant  (mode_grant),
      .ballots_cast(ballots_cast)
   );

   // Reference model: ballot lifecycle as a phase plus an age, and the run
   // length of identical single-button samples seen while the ballot is open.
   int          m_phase;   // 0 idle, 1 open, 2 vote cycle, 3 awaiting release
   int          m_age;
   int          m_run;
   int          m_cast;
   logic        m_rejd;
   logic [3:0]  m_cand;
   logic [3:0]  m_q;
   logic        m_vv, m_rej, m_tmo, m_mg;
   logic [1:0]  m_vc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [22:0] dut_vec();
      return {ballot_open, vote_valid, vote_cand, reject, timeout, mode_grant, ballots_cast};
   endfunction

   function automatic logic [22:0] model_vec();
      logic [15:0] cast;
`ifdef BALLOT_AUDIT_EN
      cast = 16'(m_cast);
`else
      cast = '0;
`endif
      return {(m_phase == 1), m_vv, m_vc, m_rej, m_tmo, m_mg, cast};
   endfunction

   task automatic model_step();
      int bits;
      m_vv  = 1'b0;
      m_rej = 1'b0;
      m_tmo = 1'b0;
      m_mg  = 1'b0;
      if (reset) begin
         m_phase = 0; m_age = 0; m_run = 0; m_cast = 0;
         m_rejd = 1'b0; m_cand = '0; m_q = '0; m_vc = '0;
      end else begin
         bits = $countones(m_q);
         case (m_phase)
            0: begin
               if (mode) m_mg = 1'b1;
               else if (ballot_issue) begin
                  m_phase = 1; m_age = 0; m_run = 0; m_rejd = 1'b0;
               end
            end
            1: begin
               if (!m_rejd && m_run == DEB && m_q == m_cand) begin
                  m_phase = 2;
                  m_vv    = 1'b1;
                  for (int i = 0; i < 4; i++) if (m_cand[i]) m_vc = 2'(i);
                  if (m_cast < 65535) m_cast++;
               end else if (m_age == TMO - 1) begin
                  m_phase = 3;
                  m_tmo   = 1'b1;
               end else begin
                  m_age++;
                  if (m_rejd) begin
                     if (bits == 0) begin m_rejd = 1'b0; m_run = 0; end
                  end else if (bits == 0) begin
                     m_run = 0;
                  end else if (bits > 1) begin
                     m_rejd = 1'b1; m_rej = 1'b1; m_run = 0;
                  end else if (m_run > 0 && m_q == m_cand) begin
                     m_run++;
                  end else begin
                     m_cand = m_q; m_run = 1;
                  end
               end
            end
            2: m_phase = 3;
            default: if (m_q == '0) m_phase = 0;
         endcase
         m_q = btn;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      cyc++;
      check("model", 32'(dut_vec()), 32'(model_vec()));
   endtask

   typedef struct {
      logic       issue;
      logic       md;
      logic [3:0] b;
      logic [6:0] exp;   // {open, vote_valid, vote_cand, reject, timeout, mode_grant}
   } vec_t;

   vec_t tbl[14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [22:0] v;
      int seen, found, vv_cnt;
      logic [3:0] hold;
      int r;

      // Button2 held 8 cycles, then readout requests in IDLE.
      tbl[0]  = '{1'b1, 1'b0, 4'b0000, 7'b1_0_00_0_0_0};
      tbl[1]  = '{1'b0, 1'b0, 4'b0010, 7'b1_0_00_0_0_0};
      tbl[2]  = '{1'b0, 1'b0, 4'b0010, 7'b1_0_00_0_0_0};
      tbl[3]  = '{1'b0, 1'b0, 4'b0010, 7'b1_0_00_0_0_0};
      tbl[4]  = '{1'b0, 1'b0, 4'b0010, 7'b1_0_00_0_0_0};
      tbl[5]  = '{1'b0, 1'b0, 4'b0010, 7'b1_0_00_0_0_0};
      tbl[6]  = '{1'b0, 1'b0, 4'b0010, 7'b0_1_01_0_0_0};
      tbl[7]  = '{1'b0, 1'b0, 4'b0010, 7'b0_0_01_0_0_0};
      tbl[8]  = '{1'b0, 1'b0, 4'b0010, 7'b0_0_01_0_0_0};
      tbl[9]  = '{1'b0, 1'b0, 4'b0000, 7'b0_0_01_0_0_0};
      tbl[10] = '{1'b0, 1'b0, 4'b0000, 7'b0_0_01_0_0_0};
      tbl[11] = '{1'b0, 1'b1, 4'b0000, 7'b0_0_01_0_0_1};
      tbl[12] = '{1'b1, 1'b1, 4'b0000, 7'b0_0_01_0_0_1};
      tbl[13] = '{1'b0, 1'b0, 4'b0000, 7'b0_0_01_0_0_0};

      reset = 1'b1; ballot_issue = 1'b0; mode = 1'b0; btn = '0;
      tick();
      tick();
      check("reset_state", 32'(dut_vec()), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         ballot_issue = tbl[i].issue;
         mode         = tbl[i].md;
         btn          = tbl[i].b;
         tick();
         v = dut_vec();
         check($sformatf("tbl[%0d]", i), 32'(v[22:16]), 32'(tbl[i].exp));
      end

      // Multi-press rejected once, ballot stays open, then button4 votes.
      ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
      btn = 4'b0110; tick(); tick();
      check("multi_reject", 32'(reject), 32'd1);
      check("multi_open", 32'(ballot_open), 32'd1);
      tick();
      check("reject_once", 32'(reject), 32'd0);
      check("reject_open", 32'(ballot_open), 32'd1);
      btn = 4'b0000; tick(); tick();
      btn = 4'b1000; seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (vote_valid) begin
            seen++;
            check("cand_button4", 32'(vote_cand), 32'd3);
         end
      end
      check("button4_votes", 32'(seen), 32'd1);
      btn = 4'b0000; tick(); tick(); tick();

      // Short press then a full hold: debounce restarts, one vote for button1.
      ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
      btn = 4'b0001; tick(); tick();
      btn = 4'b0000; tick(); tick();
      btn = 4'b0001; seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (k == 6) btn = 4'b0000;
         tick();
         if (vote_valid) begin
            seen++;
            check("cand_button1", 32'(vote_cand), 32'd0);
         end
      end
      check("restart_votes", 32'(seen), 32'd1);

      // Unused ballot expires BALLOT_TIMEOUT cycles after issue.
      ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
      found = 0; vv_cnt = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (timeout && found == 0) found = k;
         if (vote_valid) vv_cnt++;
      end
      check("timeout_cycle", 32'(found), 32'd50);
      check("timeout_no_vote", 32'(vv_cnt), 32'd0);
      check("timeout_idle", 32'(ballot_open), 32'd0);

      // Readout granted only while idle; mode during a ballot is ignored.
      mode = 1'b1; tick(); tick();
      check("grant_idle", 32'(mode_grant), 32'd1);
      mode = 1'b0; ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
      mode = 1'b1; tick(); tick();
      check("grant_in_ballot", 32'(mode_grant), 32'd0);
      check("open_in_ballot", 32'(ballot_open), 32'd1);
      mode = 1'b0; btn = 4'b0100; seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (vote_valid) begin
            seen++;
            check("cand_button3", 32'(vote_cand), 32'd2);
         end
      end
      check("mode_ballot_votes", 32'(seen), 32'd1);
      btn = 4'b0000; tick(); tick(); tick();

      // Reset mid-debounce discards the ballot.
      ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
      btn = 4'b1000; tick(); tick(); tick(); tick();
      reset = 1'b1; tick();
      check("reset_mid_ballot", 32'(dut_vec()), 32'd0);
      reset = 1'b0; btn = 4'b0000; vv_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (vote_valid) vv_cnt++;
      end
      check("reset_no_vote", 32'(vv_cnt), 32'd0);

      // Three votes for the audit count.
      for (int n = 0; n < 3; n++) begin
         ballot_issue = 1'b1; tick(); ballot_issue = 1'b0;
         btn = 4'b0001;
         for (int k = 0; k < 7; k++) tick();
         btn = 4'b0000; tick(); tick(); tick();
      end
`ifdef BALLOT_AUDIT_EN
      check("ballots_cast", 32'(ballots_cast), 32'd3);
`else
      check("ballots_cast", 32'(ballots_cast), 32'd0);
`endif

      // Randomized traffic; buttons change occasionally so presses can settle.
      hold = '0;
      for (int k = 0; k < 3000; k++) begin
         reset        = ($urandom_range(0, 199) == 0);
         ballot_issue = ($urandom_range(0, 3) == 0);
         mode         = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      hold = '0;
            else if (r < 9) hold = 4'(1 << $urandom_range(0, 3));
            else            hold = 4'($urandom_range(0, 15));
         end
         btn = hold;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
